div_n: RTL
==========

# div_n

Sequential unsigned N-bit divider computing quotient and remainder with one restoring subtract-and-shift step per clock. It is the inverse companion to the adder/subtractor datapath: it consumes operands through a start/busy/done handshake and produces `q_o = a / b` and `r_o = a % b` after N iteration cycles. It sits beside the arithmetic units as a multi-cycle functional unit, so callers must wait for `done_o` instead of reading results combinationally.

## Interface

- `N`, default 8, operand, quotient and remainder width; legal for N ≥ 2.
- `clk`  input  1  clock; all state changes on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `start`  input  1  request a division; sampled only in IDLE.
- `dvd_in`  input  N  dividend, unsigned; sampled with `start`.
- `dvs_in`  input  N  divisor, unsigned; sampled with `start`.
- `busy_o`  output  1  high whenever the state is not IDLE.
- `done_o`  output  1  one-cycle pulse; results valid.
- `q_o`  output  N  quotient; holds its value until the next completion.
- `r_o`  output  N  remainder; holds its value until the next completion.
- `dbz_o`  output  1  divide-by-zero flag for the last result; holds with `q_o`/`r_o`.

## Operation

- States: IDLE, CALC, DONE.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - `busy_o`, `done_o`, `q_o`, `r_o` and `dbz_o` are all 0.
  - Internal registers are cleared.
- IDLE, `start` = 1, `dvs_in` ≠ 0:
  - Latch dividend into quotient shift register `qs`.
  - Latch divisor into `dvs`.
  - Clear working remainder `rem` (N+1 bits).
  - Load iteration counter with N.
  - Go to CALC.
- IDLE, `start` = 1, `dvs_in` = 0:
  - Go directly to DONE.
  - Stage `q` = all ones, `r` = `dvd_in`, `dbz` = 1.
- IDLE, `start` = 0: stay in IDLE.
- CALC, each cycle:
  - `t = {rem[N-1:0], qs[N-1]}` (N+1 bits).
  - `d = t − {1'b0, dvs}` (N+1 bits).
  - If `d[N]` = 0: `rem ← d`, `qs ← {qs[N-2:0], 1}`.
  - Otherwise: `rem ← t`, `qs ← {qs[N-2:0], 0}`.
  - Decrement the counter.
  - On the iteration that takes the counter from 1 to 0, go to DONE.
- Entry to DONE:
  - `q_o ← qs` result, `r_o ← rem[N-1:0]`, `dbz_o ← dbz`.
  - `done_o` = 1 for exactly one cycle.
- DONE: unconditionally return to IDLE next edge.
- `start` in CALC or DONE is ignored; no queuing. The operand inputs are don't-care outside the accepting edge.
- `q_o`/`r_o`/`dbz_o` never change during CALC; the previous result stays readable.
- Arithmetic:
  - All values are unsigned, no overflow possible.
  - Invariant at completion for `b` ≠ 0: `q·b + r = a` and `r < b`.

## Timing

- Edge 0: `start` sampled in IDLE.
- Nonzero divisor:
  - CALC occupies edges 1..N.
  - Outputs update and `done_o` rises after edge N.
  - `done_o` falls after edge N+1.
- Zero divisor: outputs update and `done_o` pulses after edge 0, giving 1-cycle latency.
- `busy_o` is high from after edge 0 until after the edge leaving DONE.
- Back-to-back: earliest next accepted `start` is at edge N+2, the first IDLE edge. Throughput is one division per N+2 cycles.
- Reset mid-CALC aborts the operation:
  - No `done_o`.
  - Outputs go to 0 immediately; reset is asynchronous.
- Reset deassertion is synchronized externally; the first accepted `start` is the first rising edge with `rst_n` = 1.

## Test plan

- N=8, 100/7, `start` 1 cycle -> `busy_o` 1 for 9 cycles; `done_o` pulses 8 cycles after start edge; `q_o`=14, `r_o`=2, `dbz_o`=0.
- 255/1, then 5/9, then 255/255 -> (255,0), (0,5), (1,0). Each result holds unchanged through the following CALC until its own `done_o`.
- 77/0 -> `done_o` one cycle after start; `q_o`=255, `r_o`=77, `dbz_o`=1. The next valid division clears `dbz_o` at its completion.
- `start` held high continuously with 200/3 -> accepted every 10 cycles; pulses `done_o` each time with `q_o`=66, `r_o`=2. Operand changes during CALC have no effect.
- Assert `rst_n`=0 at CALC cycle 4 of 100/7 -> all outputs 0 immediately, no `done_o`. After release, 9/4 gives `q_o`=2, `r_o`=1.
- Random sweep, N=8 and N=16, 10k pairs including 0, 1 and max -> reference-model match; `done_o` at exactly N cycles, or 1 cycle for divide-by-zero.

Source files
------------

// File: rtl/div_n.sv
// Sequential unsigned restoring divider: one subtract-and-shift step per clock,
// start/busy/done handshake, divide-by-zero reported through dbz_o.
module div_n #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dvd_in,
  input  logic [N-1:0] dvs_in,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] q_o,
  output logic [N-1:0] r_o,
  output logic         dbz_o
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [N-1:0]  qs;
  logic [N-1:0]  dvs;
  // Working remainder stays below the divisor, so its top bit is always zero
  // and only N bits are stored.
  logic [N-1:0]  rem;
  logic [CW-1:0] cnt;
  logic [N:0]    t;
  logic [N:0]    d;
  logic [N-1:0]  qs_nx;
  logic [N-1:0]  rem_nx;

  always_comb begin
    t = {rem, qs[N-1]};
    d = t - {1'b0, dvs};
    if (!d[N]) begin
      rem_nx = d[N-1:0];
      qs_nx  = {qs[N-2:0], 1'b1};
    end else begin
      rem_nx = t[N-1:0];
      qs_nx  = {qs[N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      qs     <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      q_o    <= '0;
      r_o    <= '0;
      dbz_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start) begin
            busy_o <= 1'b1;
            if (dvs_in != '0) begin
              qs    <= dvd_in;
              dvs   <= dvs_in;
              rem   <= '0;
              cnt   <= CW'(N);
              state <= CALC;
            end else begin
              q_o    <= '1;
              r_o    <= dvd_in;
              dbz_o  <= 1'b1;
              done_o <= 1'b1;
              state  <= DONE;
            end
          end
        end
        CALC: begin
          qs  <= qs_nx;
          rem <= rem_nx;
          cnt <= cnt - CW'(1);
          // Final step publishes the freshly shifted values, not the registers.
          if (cnt == CW'(1)) begin
            q_o    <= qs_nx;
            r_o    <= rem_nx;
            dbz_o  <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
